// File: rtl/spi_target_if.sv
// Host-side handshake bundle for the SPI target: received bytes out, bytes to send in.
interface spi_target_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_overrun;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_underrun;

  // The SPI target drives the rx side and accepts the tx side.
  modport slave (
    output rx_data, rx_valid, rx_overrun, tx_ready, tx_underrun,
    input  rx_ready, tx_data, tx_valid
  );

  // The host logic consumes received bytes and supplies bytes to send.
  modport master (
    input  rx_data, rx_valid, rx_overrun, tx_ready, tx_underrun,
    output rx_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/spi_target.sv
// SPI mode-0 target. The SPI pins are oversampled in clk_core, MOSI is
// deserialised into bytes with a valid/ready handshake, and bytes from a
// one-entry holding register are serialised onto MISO.
// SYNC_STAGES must be at least 2.
module spi_target #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
  input  logic         clk_core,
  input  logic         reset_n,
  input  logic         spi_cs_n_i,
  input  logic         spi_sck_i,
  input  logic         spi_mosi_i,
  output logic         spi_miso_o,
  output logic         spi_miso_oe_o,
  output logic         busy_o,
  spi_target_if.slave  host
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  logic [1:0]             rstSync_q;
  logic                   rstN;
  logic [SYNC_STAGES-1:0] csSync_q, sckSync_q, mosiSync_q;
  logic [SYNC_STAGES-1:0] primed_q;
  logic                   csDly_q, sckDly_q, armed_q;
  logic                   csS, sckS, mosiS;
  logic                   sckRise, sckFall, csFall;

  state_t      state_q, state_d;
  logic [2:0]  bitCnt_q, bitCnt_d;
  logic [6:0]  rxShift_q, rxShift_d;
  logic [6:0]  txRest_q, txRest_d;
  logic        miso_q, miso_d;
  logic [7:0]  rxData_q, rxData_d;
  logic        rxValid_q, rxValid_d;
  logic        rxOverrun_q, rxOverrun_d;
  logic [7:0]  txHold_q, txHold_d;
  logic        txFull_q, txFull_d;
  logic        txUnderrun_q, txUnderrun_d;
  logic        loadNow;

  // Reset asserts asynchronously but is released in step with clk_core.
  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) rstSync_q <= 2'b00;
    else          rstSync_q <= {rstSync_q[0], 1'b1};
  end

  assign rstN = rstSync_q[1];

  // Pin synchronizers plus one delayed copy for edge detection; armed_q only
  // sets once a genuinely sampled high CS is seen, so a CS already low at
  // reset release cannot start a frame.
  always_ff @(posedge clk_core or negedge rstN) begin
    if (!rstN) begin
      csSync_q   <= '1;
      sckSync_q  <= '0;
      mosiSync_q <= '0;
      primed_q   <= '0;
      csDly_q    <= 1'b1;
      sckDly_q   <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      csSync_q   <= {csSync_q[SYNC_STAGES-2:0], spi_cs_n_i};
      sckSync_q  <= {sckSync_q[SYNC_STAGES-2:0], spi_sck_i};
      mosiSync_q <= {mosiSync_q[SYNC_STAGES-2:0], spi_mosi_i};
      primed_q   <= {primed_q[SYNC_STAGES-2:0], 1'b1};
      csDly_q    <= csS;
      sckDly_q   <= sckS;
      armed_q    <= armed_q | (primed_q[SYNC_STAGES-1] & csS);
    end
  end

  assign csS     = csSync_q[SYNC_STAGES-1];
  assign sckS    = sckSync_q[SYNC_STAGES-1];
  assign mosiS   = mosiSync_q[SYNC_STAGES-1];
  assign sckRise = sckS & ~sckDly_q;
  assign sckFall = ~sckS & sckDly_q;
  assign csFall  = ~csS & csDly_q & armed_q;

  // Frame state register.
  always_ff @(posedge clk_core or negedge rstN) begin
    if (!rstN) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state plus all datapath updates: handshakes, shifting, byte loads.
  always_comb begin
    state_d      = state_q;
    bitCnt_d     = bitCnt_q;
    rxShift_d    = rxShift_q;
    txRest_d     = txRest_q;
    miso_d       = miso_q;
    rxData_d     = rxData_q;
    rxValid_d    = rxValid_q;
    rxOverrun_d  = 1'b0;
    txHold_d     = txHold_q;
    txFull_d     = txFull_q;
    txUnderrun_d = 1'b0;
    loadNow      = 1'b0;

    if (rxValid_q && host.rx_ready) rxValid_d = 1'b0;

    if (host.tx_valid && !txFull_q) begin
      txHold_d = host.tx_data;
      txFull_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        miso_d   = 1'b1;
        bitCnt_d = 3'd0;
        if (csFall) state_d = LOAD;
      end
      LOAD: begin
        loadNow = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (csS) begin
          state_d = IDLE;
        end else begin
          if (sckRise) begin
            rxShift_d = {rxShift_q[5:0], mosiS};
            bitCnt_d  = bitCnt_q + 3'd1;
            if (bitCnt_q == 3'd7) begin
              if (!rxValid_q || host.rx_ready) begin
                rxData_d  = {rxShift_q, mosiS};
                rxValid_d = 1'b1;
              end else begin
                rxOverrun_d = 1'b1;
              end
            end
          end
          if (sckFall) begin
            if (bitCnt_q == 3'd0) begin
              loadNow = 1'b1;
            end else begin
              miso_d   = txRest_q[6];
              txRest_d = {txRest_q[5:0], 1'b0};
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A load only sees what was held at the start of the cycle; a byte
    // written in the same cycle waits for the next boundary.
    if (loadNow) begin
      if (txFull_q) begin
        miso_d   = txHold_q[7];
        txRest_d = txHold_q[6:0];
        txFull_d = 1'b0;
      end else begin
        miso_d       = IDLE_BYTE[7];
        txRest_d     = IDLE_BYTE[6:0];
        txUnderrun_d = 1'b1;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_core or negedge rstN) begin
    if (!rstN) begin
      bitCnt_q     <= 3'd0;
      rxShift_q    <= 7'd0;
      txRest_q     <= 7'd0;
      miso_q       <= 1'b1;
      rxData_q     <= 8'd0;
      rxValid_q    <= 1'b0;
      rxOverrun_q  <= 1'b0;
      txHold_q     <= 8'd0;
      txFull_q     <= 1'b0;
      txUnderrun_q <= 1'b0;
    end else begin
      bitCnt_q     <= bitCnt_d;
      rxShift_q    <= rxShift_d;
      txRest_q     <= txRest_d;
      miso_q       <= miso_d;
      rxData_q     <= rxData_d;
      rxValid_q    <= rxValid_d;
      rxOverrun_q  <= rxOverrun_d;
      txHold_q     <= txHold_d;
      txFull_q     <= txFull_d;
      txUnderrun_q <= txUnderrun_d;
    end
  end

  assign spi_miso_o       = miso_q;
  assign spi_miso_oe_o    = (state_q != IDLE);
  assign busy_o           = (state_q != IDLE);
  assign host.rx_data     = rxData_q;
  assign host.rx_valid    = rxValid_q;
  assign host.rx_overrun  = rxOverrun_q;
  assign host.tx_ready    = ~txFull_q;
  assign host.tx_underrun = txUnderrun_q;

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: a bit-level SPI master plus host-side handshakes.
module tb_spi_target;
  localparam int SYNC = 2;
  localparam int HP   = 10;

  logic clkCore = 1'b0;
  logic resetN;
  logic csN, sck, mosi;
  logic miso, misoOe, busy;
  int   total = 0;
  int   bad = 0;
  int   underrunCnt = 0;
  int   overrunCnt = 0;

  spi_target_if hostIf ();

  spi_target #(.SYNC_STAGES(SYNC), .IDLE_BYTE(8'hFF)) dut (
    .clk_core      (clkCore),
    .reset_n       (resetN),
    .spi_cs_n_i    (csN),
    .spi_sck_i     (sck),
    .spi_mosi_i    (mosi),
    .spi_miso_o    (miso),
    .spi_miso_oe_o (misoOe),
    .busy_o        (busy),
    .host          (hostIf)
  );

  always #5 clkCore = ~clkCore;

  // Count one-cycle status pulses away from the active edge.
  always @(negedge clkCore) begin
    if (hostIf.tx_underrun) underrunCnt++;
    if (hostIf.rx_overrun)  overrunCnt++;
  end

  // Hard stop in case something stalls.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // One mode-0 bit: set MOSI, hold the low phase, sample MISO, raise SCK.
  // With pulseReady the host pulses rx_ready exactly in the cycle the
  // target registers this rise (pin -> SYNC flops -> edge).
  task automatic spiBit(input logic b, output logic m, input bit pulseReady);
    mosi = b;
    repeat (HP) @(posedge clkCore);
    #1;
    m   = miso;
    sck = 1'b1;
    if (pulseReady) begin
      @(posedge clkCore);
      @(posedge clkCore);
      #1 hostIf.rx_ready = 1'b1;
      @(posedge clkCore);
      #1 hostIf.rx_ready = 1'b0;
      repeat (HP - 3) @(posedge clkCore);
      #1;
    end else begin
      repeat (HP) @(posedge clkCore);
      #1;
    end
    sck = 1'b0;
  endtask

  task automatic spiByte(input logic [7:0] mo, output logic [7:0] mi);
    logic m;
    for (int i = 7; i >= 0; i--) begin
      spiBit(mo[i], m, 1'b0);
      mi[i] = m;
    end
  endtask

  task automatic csLow();
    csN = 1'b0;
    repeat (HP) @(posedge clkCore);
    #1;
  endtask

  task automatic csHigh();
    repeat (HP) @(posedge clkCore);
    #1 csN = 1'b1;
    repeat (2 * HP) @(posedge clkCore);
    #1;
  endtask

  task automatic pushTx(input logic [7:0] b);
    int n = 0;
    while (!hostIf.tx_ready && n < 50) begin
      @(posedge clkCore);
      #1 n++;
    end
    total++;
    if (hostIf.tx_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL pushTx_ready: got=%b want=1", hostIf.tx_ready);
    end
    hostIf.tx_valid = 1'b1;
    hostIf.tx_data  = b;
    @(posedge clkCore);
    #1 hostIf.tx_valid = 1'b0;
  endtask

  task automatic consumeRx();
    hostIf.rx_ready = 1'b1;
    @(posedge clkCore);
    #1 hostIf.rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    csN = 1'b0; sck = 1'b0; mosi = 1'b0;
    repeat (3) @(posedge clkCore);
    #1;
    for (int i = 0; i < 4; i++) begin
      sck = ~sck; mosi = ~mosi;
      repeat (3) @(posedge clkCore);
      #1;
    end
    total++; if (miso !== 1'b1) begin bad++; $display("[TB] FAIL reset_miso: got=%b want=1", miso); end
    total++; if (misoOe !== 1'b0) begin bad++; $display("[TB] FAIL reset_oe: got=%b want=0", misoOe); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got=%b want=0", busy); end
    total++; if (hostIf.rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rx_valid: got=%b want=0", hostIf.rx_valid); end
    total++; if (hostIf.rx_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_rx_data: got=%h want=00", hostIf.rx_data); end
    total++; if (hostIf.tx_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_tx_ready: got=%b want=1", hostIf.tx_ready); end
    resetN = 1'b1;
    // CS stays low and SCK keeps toggling: the target must not start a frame.
    for (int i = 0; i < 12; i++) begin
      sck = ~sck; mosi = ~mosi;
      repeat (HP) @(posedge clkCore);
      #1;
    end
    total++; if (misoOe !== 1'b0) begin bad++; $display("[TB] FAIL postrst_oe: got=%b want=0", misoOe); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL postrst_busy: got=%b want=0", busy); end
    total++; if (hostIf.rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL postrst_rx_valid: got=%b want=0", hostIf.rx_valid); end
    csN = 1'b1;
    repeat (HP) @(posedge clkCore);
    #1 csN = 1'b0;
    repeat (6) @(posedge clkCore);
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL rearm_busy: got=%b want=1", busy); end
    total++; if (misoOe !== 1'b1) begin bad++; $display("[TB] FAIL rearm_oe: got=%b want=1", misoOe); end
    csHigh();
  endtask

  task automatic test_basic();
    logic [7:0] mi;
    pushTx(8'hA5);
    total++; if (hostIf.tx_ready !== 1'b0) begin bad++; $display("[TB] FAIL basic_hold_full: got=%b want=0", hostIf.tx_ready); end
    csLow();
    total++; if (hostIf.tx_ready !== 1'b1) begin bad++; $display("[TB] FAIL basic_tx_ready_after_load: got=%b want=1", hostIf.tx_ready); end
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL basic_busy: got=%b want=1", busy); end
    spiByte(8'h3C, mi);
    total++; if (mi !== 8'hA5) begin bad++; $display("[TB] FAIL basic_miso_byte: got=%h want=a5", mi); end
    total++; if (hostIf.rx_data !== 8'h3C) begin bad++; $display("[TB] FAIL basic_rx_data: got=%h want=3c", hostIf.rx_data); end
    total++; if (hostIf.rx_valid !== 1'b1) begin bad++; $display("[TB] FAIL basic_rx_valid: got=%b want=1", hostIf.rx_valid); end
    csHigh();
    total++; if (misoOe !== 1'b0) begin bad++; $display("[TB] FAIL basic_oe_idle: got=%b want=0", misoOe); end
    consumeRx();
    total++; if (hostIf.rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL basic_consume: got=%b want=0", hostIf.rx_valid); end
  endtask

  // Second byte finds the holding register empty and rx still unconsumed.
  task automatic test_overrun();
    logic [7:0] m0, m1;
    pushTx(8'h5A);
    csLow();
    underrunCnt = 0;
    overrunCnt  = 0;
    spiByte(8'h01, m0);
    spiByte(8'h02, m1);
    total++; if (m0 !== 8'h5A) begin bad++; $display("[TB] FAIL ovr_miso0: got=%h want=5a", m0); end
    total++; if (m1 !== 8'hFF) begin bad++; $display("[TB] FAIL ovr_miso1: got=%h want=ff", m1); end
    total++; if (underrunCnt !== 1) begin bad++; $display("[TB] FAIL ovr_underrun_cnt: got=%0d want=1", underrunCnt); end
    total++; if (overrunCnt !== 1) begin bad++; $display("[TB] FAIL ovr_overrun_cnt: got=%0d want=1", overrunCnt); end
    total++; if (hostIf.rx_data !== 8'h01) begin bad++; $display("[TB] FAIL ovr_rx_data: got=%h want=01", hostIf.rx_data); end
    total++; if (hostIf.rx_valid !== 1'b1) begin bad++; $display("[TB] FAIL ovr_rx_valid: got=%b want=1", hostIf.rx_valid); end
    csHigh();
    consumeRx();
  endtask

  // Consume lands in the very cycle the second byte completes.
  task automatic test_ready_at_completion();
    logic [7:0] m0;
    logic       m;
    logic [7:0] b1;
    b1 = 8'h02;
    csLow();
    overrunCnt = 0;
    spiByte(8'h11, m0);
    total++; if (hostIf.rx_data !== 8'h11) begin bad++; $display("[TB] FAIL rdy_first_data: got=%h want=11", hostIf.rx_data); end
    for (int i = 7; i >= 1; i--) spiBit(b1[i], m, 1'b0);
    spiBit(b1[0], m, 1'b1);
    total++; if (hostIf.rx_data !== 8'h02) begin bad++; $display("[TB] FAIL rdy_rx_data: got=%h want=02", hostIf.rx_data); end
    total++; if (hostIf.rx_valid !== 1'b1) begin bad++; $display("[TB] FAIL rdy_rx_valid: got=%b want=1", hostIf.rx_valid); end
    total++; if (overrunCnt !== 0) begin bad++; $display("[TB] FAIL rdy_overrun_cnt: got=%0d want=0", overrunCnt); end
    csHigh();
    consumeRx();
  endtask

  task automatic test_cs_abort();
    logic       m;
    logic [7:0] mi;
    pushTx(8'hC3);
    csLow();
    overrunCnt = 0;
    for (int i = 0; i < 5; i++) spiBit(i[0], m, 1'b0);
    repeat (HP) @(posedge clkCore);
    #1 csN = 1'b1;
    repeat (SYNC + 2) @(posedge clkCore);
    #1;
    total++; if (misoOe !== 1'b0) begin bad++; $display("[TB] FAIL abort_oe: got=%b want=0", misoOe); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL abort_busy: got=%b want=0", busy); end
    repeat (2 * HP) @(posedge clkCore);
    #1;
    total++; if (hostIf.rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL abort_rx_valid: got=%b want=0", hostIf.rx_valid); end
    total++; if (overrunCnt !== 0) begin bad++; $display("[TB] FAIL abort_overrun: got=%0d want=0", overrunCnt); end
    pushTx(8'h96);
    csLow();
    spiByte(8'hE7, mi);
    total++; if (mi !== 8'h96) begin bad++; $display("[TB] FAIL abort_next_miso: got=%h want=96", mi); end
    total++; if (hostIf.rx_data !== 8'hE7) begin bad++; $display("[TB] FAIL abort_next_rx: got=%h want=e7", hostIf.rx_data); end
    csHigh();
    consumeRx();
  endtask

  // tx write in the LOAD cycle itself: FF goes out first, the byte follows.
  task automatic test_load_write();
    logic [7:0] m0, m1;
    underrunCnt = 0;
    csN = 1'b0;
    repeat (SYNC + 1) @(posedge clkCore);
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL lw_busy_in_load: got=%b want=1", busy); end
    hostIf.tx_valid = 1'b1;
    hostIf.tx_data  = 8'h7E;
    @(posedge clkCore);
    #1 hostIf.tx_valid = 1'b0;
    spiByte(8'h44, m0);
    spiByte(8'h55, m1);
    total++; if (m0 !== 8'hFF) begin bad++; $display("[TB] FAIL lw_miso0: got=%h want=ff", m0); end
    total++; if (m1 !== 8'h7E) begin bad++; $display("[TB] FAIL lw_miso1: got=%h want=7e", m1); end
    total++; if (underrunCnt !== 1) begin bad++; $display("[TB] FAIL lw_underrun_cnt: got=%0d want=1", underrunCnt); end
    total++; if (hostIf.rx_data !== 8'h44) begin bad++; $display("[TB] FAIL lw_rx_data: got=%h want=44", hostIf.rx_data); end
    csHigh();
    consumeRx();
  endtask

  initial begin
    hostIf.rx_ready = 1'b0;
    hostIf.tx_valid = 1'b0;
    hostIf.tx_data  = 8'h00;
    test_reset();
    test_basic();
    test_overrun();
    test_ready_at_completion();
    test_cs_abort();
    test_load_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
